// File: rtl/gnn_io_pkg.sv
// Shared types and sizing constants for the GNN stream adapter.
package gnn_io_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } gnn_io_state_t;

    localparam int NUM_FEAT_BEATS = 16;
    localparam int NUM_WH_BEATS   = 16;
    localparam int NUM_WO_BEATS   = 8;
    localparam int LOAD_BEATS     = 40;
    localparam int NUM_RESULTS    = 8;

    localparam int BEAT_CNT_W = 6;
    localparam int RES_IDX_W  = 3;

    // True for the final beat of a load sequence.
    function automatic logic is_last_beat(input logic [BEAT_CNT_W-1:0] cnt);
        return (cnt == BEAT_CNT_W'(LOAD_BEATS - 1));
    endfunction

endpackage

// File: rtl/gnn_result_serializer.sv
// Captures the eight core results in one cycle and emits them one per
// handshake on a valid/ready stream, flagging the final beat.
module gnn_result_serializer
    import gnn_io_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 21
)
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                capture,
    input  logic                                start,
    input  logic [NUM_RESULTS*OUTPUT_WIDTH-1:0] results,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [OUTPUT_WIDTH-1:0]             m_data,
    output logic                                m_last,
    output logic                                done
);

    localparam logic [RES_IDX_W-1:0] RES_LAST = RES_IDX_W'(NUM_RESULTS - 1);

    logic [OUTPUT_WIDTH-1:0] cap_r [NUM_RESULTS];
    logic [RES_IDX_W-1:0]    res_idx_r;
    logic [RES_IDX_W-1:0]    res_inc_s;
    logic                    m_valid_r;
    logic                    m_last_r;
    logic [OUTPUT_WIDTH-1:0] m_data_r;
    logic                    hs_s;

    assign res_inc_s = res_idx_r + RES_IDX_W'(1);
    assign hs_s      = m_valid_r && m_ready;
    assign done      = hs_s && (res_idx_r == RES_LAST);

    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;

    // Snapshot all results at once so the core may move on while we send.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RESULTS; i++) cap_r[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_RESULTS; i++)
                cap_r[i] <= results[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
        end else begin
            for (int i = 0; i < NUM_RESULTS; i++) cap_r[i] <= cap_r[i];
        end
    end

    // Output stream: first beat comes straight from the live inputs on start,
    // later beats from the capture buffer; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
            res_idx_r <= '0;
        end else if (start) begin
            m_valid_r <= 1'b1;
            m_last_r  <= 1'b0;
            m_data_r  <= results[0 +: OUTPUT_WIDTH];
            res_idx_r <= '0;
        end else if (hs_s) begin
            if (res_idx_r == RES_LAST) begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
                m_data_r  <= '0;
                res_idx_r <= '0;
            end else begin
                m_valid_r <= 1'b1;
                m_last_r  <= (res_inc_s == RES_LAST);
                m_data_r  <= cap_r[res_inc_s];
                res_idx_r <= res_inc_s;
            end
        end else begin
            m_valid_r <= m_valid_r;
            m_last_r  <= m_last_r;
            m_data_r  <= m_data_r;
            res_idx_r <= res_idx_r;
        end
    end

endmodule

// File: rtl/gnn_stream_adapter.sv
// Stream adapter for one 4-node GNN core: deserialises the 40-beat load
// stream onto the parallel feature/weight buses, strobes the core, waits
// for all results and hands them to the result serialiser.
module gnn_stream_adapter
    import gnn_io_pkg::*;
#(
    parameter int DATA_WIDTH   = 5,
    parameter int OUTPUT_WIDTH = 21,
    parameter int GNN_LATENCY  = 4
)
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_WIDTH-1:0]                 s_data,
    output logic [NUM_FEAT_BEATS*DATA_WIDTH-1:0]  feat_flat,
    output logic [NUM_WH_BEATS*DATA_WIDTH-1:0]    w_hidden_flat,
    output logic [NUM_WO_BEATS*DATA_WIDTH-1:0]    w_out_flat,
    output logic                                  gnn_in_ready,
    input  logic [NUM_RESULTS*OUTPUT_WIDTH-1:0]   gnn_out_flat,
    input  logic [NUM_RESULTS-1:0]                gnn_out_ready,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [OUTPUT_WIDTH-1:0]               m_data,
    output logic                                  m_last,
    output logic                                  busy
);

    localparam int FIRE_W = (GNN_LATENCY > 1) ? $clog2(GNN_LATENCY) : 1;
    localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(GNN_LATENCY - 1);
    localparam int WH_BASE = NUM_FEAT_BEATS;
    localparam int WO_BASE = NUM_FEAT_BEATS + NUM_WH_BEATS;

    gnn_io_state_t           state_r;
    gnn_io_state_t           state_nxt_s;
    logic [BEAT_CNT_W-1:0]   beat_cnt_r;
    logic [FIRE_W-1:0]       fire_cnt_r;
    logic [DATA_WIDTH-1:0]   slot_r [LOAD_BEATS];
    logic                    s_ready_r;
    logic                    busy_r;
    logic                    gnn_in_ready_r;
    logic                    load_hs_s;
    logic                    capture_s;
    logic                    start_s;
    logic                    ser_done_s;

    assign s_ready      = s_ready_r;
    assign busy         = busy_r;
    assign gnn_in_ready = gnn_in_ready_r;

    for (genvar k = 0; k < NUM_FEAT_BEATS; k++) begin : g_feat
        assign feat_flat[k*DATA_WIDTH +: DATA_WIDTH] = slot_r[k];
    end
    for (genvar k = 0; k < NUM_WH_BEATS; k++) begin : g_wh
        assign w_hidden_flat[k*DATA_WIDTH +: DATA_WIDTH] = slot_r[WH_BASE + k];
    end
    for (genvar k = 0; k < NUM_WO_BEATS; k++) begin : g_wo
        assign w_out_flat[k*DATA_WIDTH +: DATA_WIDTH] = slot_r[WO_BASE + k];
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_hs_s   = 1'b0;
        capture_s   = 1'b0;
        start_s     = 1'b0;
        case (state_r)
            LOAD: begin
                load_hs_s = s_valid && s_ready_r;
                if (load_hs_s && is_last_beat(beat_cnt_r)) state_nxt_s = FIRE;
                else                                       state_nxt_s = LOAD;
            end
            FIRE: begin
                if (fire_cnt_r == FIRE_LAST) state_nxt_s = WAIT;
                else                         state_nxt_s = FIRE;
            end
            WAIT: begin
                if (&gnn_out_ready) begin
                    state_nxt_s = SEND;
                    capture_s   = 1'b1;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            SEND: begin
                if (ser_done_s) state_nxt_s = LOAD;
                else            state_nxt_s = SEND;
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= LOAD;
        else     state_r <= state_nxt_s;
    end

    // Load beat position; the final beat wraps it for the next inference.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= '0;
        end else if (load_hs_s) begin
            if (is_last_beat(beat_cnt_r)) beat_cnt_r <= '0;
            else                          beat_cnt_r <= beat_cnt_r + BEAT_CNT_W'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Counts cycles spent strobing the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_cnt_r <= '0;
        end else if (state_r == FIRE) begin
            if (fire_cnt_r == FIRE_LAST) fire_cnt_r <= '0;
            else                         fire_cnt_r <= fire_cnt_r + FIRE_W'(1);
        end else begin
            fire_cnt_r <= '0;
        end
    end

    // Feature/weight slots; each beat lands in the slot its position selects
    // and every slot holds until the next load rewrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LOAD_BEATS; i++) slot_r[i] <= '0;
        end else begin
            for (int i = 0; i < LOAD_BEATS; i++) begin
                if (load_hs_s && (beat_cnt_r == BEAT_CNT_W'(i))) slot_r[i] <= s_data;
                else                                             slot_r[i] <= slot_r[i];
            end
        end
    end

    // Status outputs registered from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_r      <= 1'b0;
            busy_r         <= 1'b0;
            gnn_in_ready_r <= 1'b0;
        end else begin
            s_ready_r      <= (state_nxt_s == LOAD);
            busy_r         <= (state_nxt_s != LOAD);
            gnn_in_ready_r <= (state_nxt_s == FIRE);
        end
    end

    gnn_result_serializer #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .capture (capture_s),
        .start   (start_s),
        .results (gnn_out_flat),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (ser_done_s)
    );

endmodule

// File: tb/tb_gnn_stream_adapter.sv
// Self-checking bench for gnn_stream_adapter: a table of inference runs
// (load pattern, result set, backpressure and abort points) plus reset checks.
module tb_gnn_stream_adapter;

    localparam int DW  = 5;
    localparam int OW  = 21;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic [16*DW-1:0] feat_flat;
    logic [16*DW-1:0] w_hidden_flat;
    logic [8*DW-1:0]  w_out_flat;
    logic            gnn_in_ready;
    logic [8*OW-1:0] gnn_out_flat;
    logic [7:0]      gnn_out_ready;
    logic            m_valid;
    logic            m_ready;
    logic [OW-1:0]   m_data;
    logic            m_last;
    logic            busy;

    always #5 clk = ~clk;

    gnn_stream_adapter #(
        .DATA_WIDTH   (DW),
        .OUTPUT_WIDTH (OW),
        .GNN_LATENCY  (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .feat_flat     (feat_flat),
        .w_hidden_flat (w_hidden_flat),
        .w_out_flat    (w_out_flat),
        .gnn_in_ready  (gnn_in_ready),
        .gnn_out_flat  (gnn_out_flat),
        .gnn_out_ready (gnn_out_ready),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy)
    );

    typedef logic [7:0][OW-1:0] res_t;

    typedef struct {
        int         mul;
        int         base;
        int         mask;
        bit         gap;
        res_t       res;
        logic [7:0] pre_mask;
        int         wait_n;
        int         stall_beat;
        int         stall_len;
        int         abort_load;
        int         abort_send;
    } vec_t;

    vec_t          tbl [6];
    logic [OW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Value of load beat i for a vector.
    function automatic logic [DW-1:0] lval(input vec_t v, input int i);
        return DW'((v.mul * i + v.base) & v.mask);
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_s_ready"},      32'(s_ready), 32'd0);
        check({tag, "_busy"},         32'(busy), 32'd0);
        check({tag, "_gnn_in_ready"}, 32'(gnn_in_ready), 32'd0);
        check({tag, "_m_valid"},      32'(m_valid), 32'd0);
        check({tag, "_m_last"},       32'(m_last), 32'd0);
        check({tag, "_m_data"},       32'(m_data), 32'd0);
        check({tag, "_feat"},         32'(|feat_flat), 32'd0);
        check({tag, "_w_hidden"},     32'(|w_hidden_flat), 32'd0);
        check({tag, "_w_out"},        32'(|w_out_flat), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        s_valid = 1'b0;
        m_ready = 1'b1;
        rst     = 1'b1;
        step();
        check_zero_outputs(tag);
        rst = 1'b0;
        step();
        check({tag, "_post_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_post_busy"},    32'(busy), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int beat;
        int cyc;
        int stalled;
        beat = 0;
        cyc  = 0;
        gnn_out_flat  = v.res;
        gnn_out_ready = v.pre_mask;
        // load phase
        while (beat < 40 && cyc < 200) begin
            if (beat == v.abort_load) begin
                apply_reset($sformatf("v%0d_abort_load", idx));
                return;
            end
            s_valid = v.gap ? ((cyc % 2) == 1) : 1'b1;
            s_data  = lval(v, beat);
            check($sformatf("v%0d_load_s_ready", idx), 32'(s_ready), 32'd1);
            check($sformatf("v%0d_load_busy", idx), 32'(busy), 32'd0);
            check($sformatf("v%0d_load_in_ready", idx), 32'(gnn_in_ready), 32'd0);
            if (s_valid && s_ready) beat++;
            step();
            cyc++;
        end
        s_valid = 1'b0;
        check($sformatf("v%0d_load_cycles", idx), 32'(cyc), v.gap ? 32'd80 : 32'd40);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("v%0d_feat%0d", idx, k), 32'(feat_flat[k*DW +: DW]), 32'(lval(v, k)));
            check($sformatf("v%0d_wh%0d", idx, k), 32'(w_hidden_flat[k*DW +: DW]), 32'(lval(v, 16 + k)));
        end
        for (int k = 0; k < 8; k++)
            check($sformatf("v%0d_wo%0d", idx, k), 32'(w_out_flat[k*DW +: DW]), 32'(lval(v, 32 + k)));
        // fire window
        for (int i = 0; i < LAT; i++) begin
            check($sformatf("v%0d_fire%0d_in_ready", idx, i), 32'(gnn_in_ready), 32'd1);
            check($sformatf("v%0d_fire%0d_busy", idx, i), 32'(busy), 32'd1);
            check($sformatf("v%0d_fire%0d_s_ready", idx, i), 32'(s_ready), 32'd0);
            step();
        end
        check($sformatf("v%0d_fire_end", idx), 32'(gnn_in_ready), 32'd0);
        // wait with incomplete ready flags
        for (int i = 0; i < v.wait_n; i++) begin
            check($sformatf("v%0d_wait%0d_m_valid", idx, i), 32'(m_valid), 32'd0);
            check($sformatf("v%0d_wait%0d_in_ready", idx, i), 32'(gnn_in_ready), 32'd0);
            step();
        end
        gnn_out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(v.res[i]);
        step();
        gnn_out_flat  = ~v.res;
        gnn_out_ready = 8'h00;
        // drain results
        beat    = 0;
        stalled = 0;
        cyc     = 0;
        while (beat < 8 && cyc < 100) begin
            if (beat == v.abort_send) begin
                apply_reset($sformatf("v%0d_abort_send", idx));
                exp_q.delete();
                return;
            end
            m_ready = (beat == v.stall_beat && stalled < v.stall_len) ? 1'b0 : 1'b1;
            check($sformatf("v%0d_r%0d_m_valid", idx, beat), 32'(m_valid), 32'd1);
            check($sformatf("v%0d_r%0d_busy", idx, beat), 32'(busy), 32'd1);
            check($sformatf("v%0d_r%0d_s_ready", idx, beat), 32'(s_ready), 32'd0);
            check($sformatf("v%0d_r%0d_m_data", idx, beat), 32'(m_data), 32'(exp_q[0]));
            check($sformatf("v%0d_r%0d_m_last", idx, beat), 32'(m_last), 32'(beat == 7));
            if (m_ready) begin
                void'(exp_q.pop_front());
                beat++;
            end else begin
                stalled++;
            end
            step();
            cyc++;
        end
        m_ready = 1'b1;
        check($sformatf("v%0d_drain_beats", idx), 32'(beat), 32'd8);
        check($sformatf("v%0d_end_m_valid", idx), 32'(m_valid), 32'd0);
        check($sformatf("v%0d_end_m_last", idx), 32'(m_last), 32'd0);
        check($sformatf("v%0d_end_busy", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_end_s_ready", idx), 32'(s_ready), 32'd1);
    endtask

    initial begin
        tbl[0] = '{mul: 1, base: 0, mask: 15, gap: 1'b0,
                   res: {21'(-1048576), 21'd6, 21'(-5), 21'd4, 21'(-3), 21'd2, 21'(-1), 21'd100},
                   pre_mask: 8'h7F, wait_n: 3, stall_beat: 3, stall_len: 5,
                   abort_load: -1, abort_send: -1};
        tbl[1] = '{mul: 1, base: 0, mask: 15, gap: 1'b1,
                   res: {21'd1, 21'd9, 21'(-2), 21'd12345, 21'd33, 21'(-7), 21'd0, 21'd1048575},
                   pre_mask: 8'h00, wait_n: 2, stall_beat: -1, stall_len: 0,
                   abort_load: -1, abort_send: -1};
        tbl[2] = '{mul: 1, base: 1, mask: 31, gap: 1'b0,
                   res: {21'd8, 21'd7, 21'd6, 21'd5, 21'd4, 21'd3, 21'd2, 21'd1},
                   pre_mask: 8'h00, wait_n: 0, stall_beat: -1, stall_len: 0,
                   abort_load: 21, abort_send: -1};
        tbl[3] = '{mul: 3, base: 2, mask: 31, gap: 1'b0,
                   res: {21'd70, 21'd60, 21'd50, 21'd40, 21'd30, 21'd20, 21'd10, 21'd5},
                   pre_mask: 8'hFF, wait_n: 0, stall_beat: -1, stall_len: 0,
                   abort_load: -1, abort_send: 4};
        tbl[4] = '{mul: 7, base: 3, mask: 31, gap: 1'b0,
                   res: {21'd1048575, 21'(-1048576), 21'd77, 21'(-77), 21'd4096, 21'(-4096), 21'd3, 21'(-300)},
                   pre_mask: 8'hFF, wait_n: 0, stall_beat: 7, stall_len: 2,
                   abort_load: -1, abort_send: -1};
        tbl[5] = '{mul: 5, base: 17, mask: 31, gap: 1'b0,
                   res: {21'(-8), 21'd99, 21'(-123456), 21'd654321, 21'd0, 21'd11, 21'(-1), 21'd2},
                   pre_mask: 8'h0F, wait_n: 1, stall_beat: 0, stall_len: 1,
                   abort_load: -1, abort_send: -1};

        rst           = 1'b1;
        s_valid       = 1'b0;
        s_data        = '0;
        gnn_out_flat  = '0;
        gnn_out_ready = 8'h00;
        m_ready       = 1'b1;
        apply_reset("init");

        for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gnn_stream_adapter.md
# gnn_stream_adapter

Streaming front/back end for the 4-node GNN core. It deserialises a narrow load stream of node features and weights into the core's parallel feature/weight buses and holds the core's `in_ready` strobe. It then waits for all eight per-output ready flags, captures the eight results and serialises them onto a valid/ready output stream. It sits between the chip-level I/O and the GNN top, one instance per core.

## Interface
Parameters:
- `DATA_WIDTH`, 5: width of one feature or weight beat (signed).
- `OUTPUT_WIDTH`, 21: width of one GNN result (signed).
- `GNN_LATENCY`, 4: cycles `gnn_in_ready` is held high per inference (≥1).

Ports (clock and reset first):
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_valid` in 1: load beat valid.
- `s_ready` out 1: adapter accepts a load beat.
- `s_data` in `DATA_WIDTH`: load beat, signed.
- `feat_flat` out 16×`DATA_WIDTH`: x0..x3 of node0, then node1, node2, node3; element 0 in LSBs.
- `w_hidden_flat` out 16×`DATA_WIDTH`: w04,w14,w24,w34,w05,…,w37; element 0 in LSBs.
- `w_out_flat` out 8×`DATA_WIDTH`: w48,w58,w68,w78,w49,w59,w69,w79; element 0 in LSBs.
- `gnn_in_ready` out 1: strobe to core `in_ready`.
- `gnn_out_flat` in 8×`OUTPUT_WIDTH`: out0_node0,out1_node0,…,out1_node3; element 0 in LSBs.
- `gnn_out_ready` in 8: per-result ready flags, same order.
- `m_valid` out 1: result beat valid.
- `m_ready` in 1: downstream accepts result.
- `m_data` out `OUTPUT_WIDTH`: result beat.
- `m_last` out 1: high with the 8th result beat.
- `busy` out 1: high in any state except LOAD.

## Operation
- FSM states: LOAD → FIRE → WAIT → SEND → LOAD.
- **LOAD**
  - `s_ready`=1. Each handshake (`s_valid && s_ready`) writes `s_data` to the slot indexed by `beat_cnt` (0..39) and increments it.
  - Beats 0–15 go to the feature slots, 16–31 to the hidden-weight slots and 32–39 to the output-weight slots.
  - The beat with `beat_cnt`=39 clears the counter and moves to FIRE.
  - Slots hold their values until rewritten, so the buses are stable through FIRE/WAIT/SEND.
- **FIRE**
  - `gnn_in_ready`=1 for exactly `GNN_LATENCY` cycles (counter `fire_cnt`), then WAIT.
- **WAIT**
  - Stays until `&gnn_out_ready`=1. In that cycle all eight results are registered into the capture buffer and the FSM moves to SEND with `res_idx`=0.
- **SEND**
  - `m_valid`=1 and `m_data`=capture[`res_idx`]. On handshake `res_idx` increments.
  - `m_last`=1 when `res_idx`=7. The handshake on `res_idx`=7 returns the FSM to LOAD.
- Widths are pure pass-through. There is no arithmetic on data and no sign extension or truncation.

## Timing
- **Reset:** all outputs are 0 while `rst` is high (`s_ready`, `gnn_in_ready`, `m_valid`, `m_last`, `busy`, all flat buses, `m_data`). State becomes LOAD and all counters clear.
- `s_ready`, `m_valid`, `m_last` and `busy` are registered. `s_ready`=1 on the first cycle after `rst` falls.
- The last load beat is accepted at edge T. Then `gnn_in_ready` is high for cycles T+1..T+`GNN_LATENCY` and `busy`=1 from T+1.
- `&gnn_out_ready` is first seen in WAIT at cycle C. Then `m_valid`=1 from C+1.
- Minimum beats per inference are 40 load plus 8 result. Back-to-back streaming gives 1 beat/cycle on each side.
- While `m_valid && !m_ready`, `m_data` and `m_last` hold stable.
- **Wait conditions:** `s_valid` low in LOAD stalls without losing position. `gnn_out_ready` already high on entry to WAIT, for example sticky flags from the previous run, is captured on the first WAIT cycle. That is legal because FIRE has spanned `GNN_LATENCY`.
- **Outside LOAD:** `s_valid` is ignored and `s_ready`=0.
- **Reset mid-operation:** aborts in any state. Partial loads and captured results are discarded, the buses return to 0 and the next load restarts at beat 0.

## Structure
- Package `gnn_io_pkg` holds:
  - state enum `gnn_io_state_t` (LOAD, FIRE, WAIT, SEND);
  - constants `NUM_FEAT_BEATS`=16, `NUM_WH_BEATS`=16, `NUM_WO_BEATS`=8, `LOAD_BEATS`=40, `NUM_RESULTS`=8.
- Sub-module `gnn_result_serializer` contains the 8-entry capture buffer, `res_idx`, the `m_*` handshake and `m_last`. The top FSM drives its `capture` and `start` inputs and receives its `done` output.

## Test plan
- **Load ordering:** stream beats 0..39 with value = index mod 16 (signed 5-bit), `s_valid` constant. Required: `feat_flat` element k = k, `w_hidden_flat` element k = k, `w_out_flat` element k = k. `gnn_in_ready` is high for exactly 4 cycles starting one cycle after beat 39.
- **Load backpressure:** toggle `s_valid` every other cycle. Required: same final bus contents as the load-ordering test, 80 cycles to complete, no skipped or duplicated slot.
- **Result capture:** hold `gnn_out_ready`=0x7F through FIRE, then raise bit 7 after 3 WAIT cycles, with `gnn_out_flat` elements = 100,−1,2,−3,4,−5,6,−1048576. Required: `m_valid` high the cycle after bit 7 rises, data emitted in that order, and `m_last` only on −1048576.
- **Output backpressure:** `m_ready` low for 5 cycles on beat 3. Required: `m_data`=−3 stable for those cycles, and no beat lost or repeated.
- **Mid-operation reset:** assert `rst` for 1 cycle after beat 20, and separately during SEND at `res_idx`=4. Required: all outputs 0, `s_ready`=1 the next cycle, and a fresh 40-beat load produces correct buses.
- **Back-to-back inferences:** two full runs with different data. Required: the second run's `gnn_in_ready` window and results are independent of the first, and `busy` falls exactly after the 8th result handshake.
